// File: rtl/mult_arb_pkg.sv
// Shared types and sizing for the mult_45 arbiter.
package mult_arb_pkg;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned WIDTH     = 45;
  localparam int unsigned MULT_LAT  = 4;
  localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TAG_DEPTH = MULT_LAT + 1;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [WIDTH-1:0]   operand_t;
  typedef logic [2*WIDTH-1:0] product_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

  // Requester index plus one, wrapping at N_REQ.
  function automatic idx_t wrap_inc(input idx_t i);
    int unsigned n;
    n = 32'(i) + 32'd1;
    return (n >= N_REQ) ? '0 : IDX_W'(n);
  endfunction

endpackage

// File: rtl/mult_45_arbiter_rr_arbiter.sv
// Combinational requester arbiter: round-robin from a pointer, or fixed
// priority (lowest index wins) when MULT_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import mult_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
`ifndef MULT_ARB_FIXED_PRIO_EN
  input  idx_t             ptr,
  output idx_t             next_ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output idx_t             grant_idx,
  output logic             grant_any
);

  int unsigned j;

  // Pick the first requester found, scanning upward from the start point.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (32'(ptr) + k) % N_REQ;
`endif
      if (!grant_any && req[IDX_W'(j)]) begin
        grant[IDX_W'(j)] = 1'b1;
        grant_idx        = IDX_W'(j);
        grant_any        = 1'b1;
      end
    end
  end

`ifndef MULT_ARB_FIXED_PRIO_EN
  // Pointer moves just past the winner; holds when nobody is granted.
  always_comb begin
    next_ptr = ptr;
    if (grant_any) begin
      next_ptr = wrap_inc(grant_idx);
    end
  end
`endif

endmodule

// File: rtl/mult_45_arbiter.sv
// Shares one fixed-latency mult_45 among N_REQ requesters; a tag pipeline
// matched to the multiplier latency steers each product back to its owner.
// Build option: MULT_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module mult_45_arbiter
  import mult_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  input  logic [2*WIDTH-1:0]     mult_p,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]     resp_p,
  output logic                   busy
);

  logic [N_REQ-1:0] grant;
  idx_t             grant_idx;
  logic             grant_any;
  operand_t         sel_a;
  operand_t         sel_b;
  tag_t             tags [TAG_DEPTH];

`ifdef MULT_ARB_FIXED_PRIO_EN
  rr_arbiter u_arb (
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );
`else
  idx_t ptr;
  idx_t next_ptr;

  rr_arbiter u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .next_ptr  (next_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      ptr <= next_ptr;
    end
  end
`endif

  // No grants are offered while reset is asserted.
  assign req_ready = grant & {N_REQ{reset_n}};

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Operand register feeding mult_45; holds when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (grant_any) begin
      mult_a <= sel_a;
      mult_b <= sel_b;
    end
  end

  // Tag pipeline: stage 0 aligns with the operand register, the last stage
  // with the product emerging from mult_45.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= tag_t'{valid: grant_any, idx: grant_idx};
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Response decode from the final tag stage.
  always_comb begin
    resp_valid = '0;
    if (reset_n && tags[TAG_DEPTH-1].valid) begin
      resp_valid[tags[TAG_DEPTH-1].idx] = 1'b1;
    end
  end

  assign resp_p = mult_p;

  // Busy whenever any tag stage holds an issued operation.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
      busy = busy | tags[i].valid;
    end
  end

endmodule

// File: tb/tb_mult_45_arbiter.sv
// Self-checking bench for mult_45_arbiter: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_mult_45_arbiter;
  import mult_arb_pkg::*;

  localparam int unsigned PW = 2 * WIDTH;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a = '0;
  logic [N_REQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [PW-1:0]          mult_p;
  logic [N_REQ-1:0]       resp_valid;
  logic [PW-1:0]          resp_p;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_45_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .resp_valid (resp_valid),
    .resp_p     (resp_p),
    .busy       (busy)
  );

  // mult_45 model: product of the operands seen, MULT_LAT cycles later.
  logic [PW-1:0] p_pipe [MULT_LAT];
  always @(posedge clk) begin
    p_pipe[0] <= PW'(mult_a) * PW'(mult_b);
    for (int k = 1; k < MULT_LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mult_p = p_pipe[MULT_LAT-1];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding operations as a queue of {issue cycle, owner, product}.
  typedef struct {
    int unsigned issue;
    int          idx;
    logic [PW-1:0] prod;
  } flight_t;

  flight_t     q[$];
  int unsigned cyc = 0;
  int          m_ptr = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;

  always @(negedge clk) begin : model
    logic [N_REQ-1:0] exp_rdy;
    logic [N_REQ-1:0] exp_rv;
    logic [PW-1:0]    exp_p;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    bit               have;
    int               win;
    int               j;
    cyc++;
    if (!reset_n) begin
      chk("rst_req_ready", PW'(req_ready), '0);
      chk("rst_resp_valid", PW'(resp_valid), '0);
      q.delete();
      m_ptr = 0;
      m_a = '0;
      m_b = '0;
    end else begin
      chk("mult_a", PW'(mult_a), PW'(m_a));
      chk("mult_b", PW'(mult_b), PW'(m_b));
      chk("busy", PW'(busy), PW'(q.size() > 0 && q[0].issue < cyc));
      exp_rv = '0;
      exp_p  = '0;
      have   = 0;
      if (q.size() > 0 && q[0].issue + 1 + MULT_LAT == cyc) begin
        exp_rv = N_REQ'(1) << q[0].idx;
        exp_p  = q[0].prod;
        have   = 1;
        void'(q.pop_front());
      end
      chk("resp_valid", PW'(resp_valid), PW'(exp_rv));
      if (have) chk("resp_p", resp_p, exp_p);
      win = -1;
      for (int k = 0; k < N_REQ; k++) begin
        j = (m_ptr + k) % N_REQ;
        if (win < 0 && req_valid[j]) win = j;
      end
      exp_rdy = (win >= 0) ? (N_REQ'(1) << win) : '0;
      chk("req_ready", PW'(req_ready), PW'(exp_rdy));
      if (win >= 0) begin
        wa = req_a[win*WIDTH +: WIDTH];
        wb = req_b[win*WIDTH +: WIDTH];
        q.push_back('{issue: cyc, idx: win, prod: PW'(wa) * PW'(wb)});
        m_a = wa;
        m_b = wb;
`ifndef MULT_ARB_FIXED_PRIO_EN
        m_ptr = (win + 1) % N_REQ;
`endif
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return WIDTH'($urandom_range(0, 15));
      default: return WIDTH'({$urandom(), $urandom()});
    endcase
  endfunction

  logic [N_REQ-1:0] hs;
  logic [PW-1:0]    max_prod;
  int               exp_g;

  initial begin
    max_prod = 90'h3FFFFFFFFFFC00000000001;

    // Reset held for three cycles, then idle.
    repeat (3) drive_edge();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_req_ready", PW'(req_ready), '0);
      chk("idle_resp_valid", PW'(resp_valid), '0);
      chk("idle_busy", PW'(busy), '0);
    end

    // All requesters continuously: one grant per cycle, products back in order.
    drive_edge();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(10);
    end
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 4;
`endif
      if (k < 8) chk("all_grant", PW'(req_ready), PW'(N_REQ'(1) << exp_g));
      if (k >= 5) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
        exp_g = 0;
`else
        exp_g = (k - 5) % 4;
`endif
        chk("all_resp_valid", PW'(resp_valid), PW'(N_REQ'(1) << exp_g));
        chk("all_resp_p", resp_p, PW'((exp_g + 1) * 10));
      end
      drive_edge();
      if (k == 7) req_valid = '0;
    end
    repeat (4) drive_edge();

    // Single request from requester 2: 3*5 after 1+MULT_LAT cycles.
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = WIDTH'(3);
    req_b[2*WIDTH +: WIDTH] = WIDTH'(5);
    @(negedge clk);
    chk("single_grant", PW'(req_ready), PW'(4'b0100));
    drive_edge();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 5) chk("single_no_resp", PW'(resp_valid), '0);
      if (k <= 5) chk("single_busy", PW'(busy), PW'(1'b1));
      if (k == 5) begin
        chk("single_resp_valid", PW'(resp_valid), PW'(4'b0100));
        chk("single_resp_p", resp_p, PW'(15));
      end
      if (k == 6) chk("single_busy_clear", PW'(busy), '0);
      drive_edge();
    end

    // Contention right after the pointer moved past requester 2.
    req_valid = 4'b0101;
    req_a[0 +: WIDTH] = WIDTH'(7);
    req_b[0 +: WIDTH] = WIDTH'(9);
    @(negedge clk);
    chk("contend_first", PW'(req_ready), PW'(4'b0001));
    drive_edge();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("contend_second", PW'(req_ready), PW'(4'b0100));
    drive_edge();
    req_valid = '0;
    repeat (8) drive_edge();

    // Full-scale operands on requester 1.
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = '1;
    req_b[1*WIDTH +: WIDTH] = '1;
    @(negedge clk);
    chk("max_grant", PW'(req_ready), PW'(4'b0010));
    drive_edge();
    req_valid = '0;
    repeat (MULT_LAT) @(posedge clk);
    @(negedge clk);
    chk("max_resp_valid", PW'(resp_valid), PW'(4'b0010));
    chk("max_resp_p", resp_p, max_prod);
    drive_edge();
    repeat (4) drive_edge();

    // Random traffic; operands only change when idle or just granted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      drive_edge();
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i*WIDTH +: WIDTH] = rnd_op();
          req_b[i*WIDTH +: WIDTH] = rnd_op();
        end
      end
    end
    @(negedge clk);
    drive_edge();
    req_valid = '0;
    repeat (10) drive_edge();

    // Reset two cycles after the last of three grants discards them.
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      drive_edge();
      req_valid = req_valid & ~hs;
    end
    drive_edge();
    reset_n = 1'b0;
    drive_edge();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", PW'(resp_valid), '0);
      chk("post_rst_busy", PW'(busy), '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
